lock_result_display: RTL and testbench

- Downstream consumer of the combination-lock FSM.
- Takes the FSM's per-digit accept strobe and final open/closed verdict, and drives the six seven-segment displays.
- During entry it shows a shifting history of entered digits, then shows "OPEn" or "CLOSEd".
- Counts consecutive failures; after MAX_FAILS failures it enters a timed, blinking "ErrOr" lockout that raises a lockout flag to the upstream lock.

---
 rtl/lock_result_display_if.sv | 31 +++
 rtl/lock_result_display.sv | 143 ++++++++++++++
 tb/tb_lock_result_display.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lock_result_display_if.sv
// Signal bundle between the combination-lock FSM (master) and the result display (slave).
interface lock_result_display_if;
  // Strobe semantics: entry_valid, done and clear are single-cycle pulses sampled on the
  // rising clock edge. There is no ready/backpressure; the display always accepts them.
  // open is meaningful only in the cycle done is high. The lock must ignore its own
  // inputs while lockout is high.
  logic [3:0] digit_in;
  logic       entry_valid;
  logic       done;
  logic       open;
  logic       clear;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic [1:0] fail_count;
  logic       lockout;
  logic [1:0] state_dbg;

  modport master (
    output digit_in, entry_valid, done, open, clear,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, fail_count, lockout, state_dbg
  );

  modport slave (
    input  digit_in, entry_valid, done, open, clear,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, fail_count, lockout, state_dbg
  );
endinterface

// File: rtl/lock_result_display.sv
// Seven-segment result display for the combination lock: digit history, OPEn/CLOSEd
// verdicts, and a timed blinking ErrOr lockout after repeated failures.
module lock_result_display #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int BLINK_CYCLES   = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  lock_result_display_if.slave bus
);

  typedef enum logic [1:0] {
    ENTRY       = 2'b00,
    SHOW_OPEN   = 2'b01,
    SHOW_CLOSED = 2'b10,
    LOCKOUT     = 2'b11
  } state_t;

  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_O     = 7'b1000000;
  localparam logic [6:0] G_P     = 7'b0001100;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_N     = 7'b0101011;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_L     = 7'b1000111;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_R     = 7'b0101111;

  state_t          state_q, state_d;
  logic [5:0][3:0] hist_q, hist_d;
  logic [5:0]      hv_q, hv_d;
  logic [1:0]      fail_q, fail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0][6:0] hex;
  logic            blink_on;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b1000000;
      4'd1:    seg_digit = 7'b1111001;
      4'd2:    seg_digit = 7'b0100100;
      4'd3:    seg_digit = 7'b0110000;
      4'd4:    seg_digit = 7'b0011001;
      4'd5:    seg_digit = 7'b0010010;
      4'd6:    seg_digit = 7'b0000010;
      4'd7:    seg_digit = 7'b1111000;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0010000;
      default: seg_digit = G_DASH;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ENTRY;
      hist_q  <= '0;
      hv_q    <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      hv_q    <= hv_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leaving ENTRY always wipes the history so every return to ENTRY starts blank.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    hv_d    = hv_q;
    fail_d  = fail_q;
    cnt_d   = '0;
    case (state_q)
      ENTRY: begin
        if (bus.done) begin
          hv_d = '0;
          if (bus.open) begin
            state_d = SHOW_OPEN;
            fail_d  = '0;
          end else if (({1'b0, fail_q} + 3'd1) >= 3'(MAX_FAILS)) begin
            state_d = LOCKOUT;
          end else begin
            state_d = SHOW_CLOSED;
            fail_d  = fail_q + 2'd1;
          end
        end else if (bus.clear) begin
          hv_d = '0;
        end else if (bus.entry_valid) begin
          hist_d = {hist_q[4:0], bus.digit_in};
          hv_d   = {hv_q[4:0], 1'b1};
        end
      end
      SHOW_OPEN, SHOW_CLOSED: begin
        if (bus.clear) state_d = ENTRY;
      end
      LOCKOUT: begin
        if (cnt_q == CW'(LOCKOUT_CYCLES - 1)) begin
          state_d = ENTRY;
          fail_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  assign blink_on = (((32'(cnt_q) / 32'(BLINK_CYCLES)) & 32'd1) == 32'd0);

  always_comb begin
    hex = {6{G_BLANK}};
    case (state_q)
      ENTRY: begin
        for (int i = 0; i < 6; i++) hex[i] = hv_q[i] ? seg_digit(hist_q[i]) : G_BLANK;
      end
      SHOW_OPEN:   hex = {G_BLANK, G_BLANK, G_O, G_P, G_E, G_N};
      SHOW_CLOSED: hex = {G_C, G_L, G_O, G_S, G_E, G_D};
      LOCKOUT: begin
        if (blink_on) hex = {G_BLANK, G_E, G_R, G_R, G_O, G_R};
      end
      default: hex = {6{G_BLANK}};
    endcase
  end

  assign bus.HEX0       = hex[0];
  assign bus.HEX1       = hex[1];
  assign bus.HEX2       = hex[2];
  assign bus.HEX3       = hex[3];
  assign bus.HEX4       = hex[4];
  assign bus.HEX5       = hex[5];
  assign bus.fail_count = fail_q;
  assign bus.lockout    = (state_q == LOCKOUT);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_lock_result_display.sv
// Directed and randomized checks of lock_result_display against a queue-based display model.
module tb_lock_result_display;

  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int BLINK_CYCLES   = 4;

  localparam logic [6:0] BL = 7'b1111111;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  lock_result_display_if bus();

  lock_result_display #(
    .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .BLINK_CYCLES(BLINK_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] dig_glyph [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  int m_mode;      // 0 entry, 1 shows OPEn, 2 shows CLOSEd, 3 locked out
  int m_digits[$]; // newest first
  int m_fail;
  int m_age;       // cycles already spent in lockout
  logic [41:0] exp_q[$];

  function automatic logic [41:0] model_display();
    logic [6:0] h [0:5];
    for (int i = 0; i < 6; i++) h[i] = BL;
    if (m_mode == 0) begin
      for (int i = 0; i < m_digits.size(); i++) h[i] = dig_glyph[m_digits[i]];
    end else if (m_mode == 1) begin
      h[3] = 7'b1000000; h[2] = 7'b0001100; h[1] = 7'b0000110; h[0] = 7'b0101011;
    end else if (m_mode == 2) begin
      h[5] = 7'b1000110; h[4] = 7'b1000111; h[3] = 7'b1000000;
      h[2] = 7'b0010010; h[1] = 7'b0000110; h[0] = 7'b0100001;
    end else if (((m_age / BLINK_CYCLES) % 2) == 0) begin
      h[4] = 7'b0000110; h[3] = 7'b0101111; h[2] = 7'b0101111;
      h[1] = 7'b1000000; h[0] = 7'b0101111;
    end
    return {h[5], h[4], h[3], h[2], h[1], h[0]};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_digits.delete();
    m_fail = 0;
    m_age  = 0;
    exp_q.delete();
    exp_q.push_back(model_display());
  endtask

  task automatic model_step(input int d, input bit ev, input bit dn, input bit op, input bit clr);
    if (m_mode == 0) begin
      if (dn) begin
        m_digits.delete();
        if (op) begin
          m_mode = 1; m_fail = 0;
        end else if (m_fail + 1 >= MAX_FAILS) begin
          m_mode = 3; m_age = 0;
        end else begin
          m_mode = 2; m_fail = m_fail + 1;
        end
      end else if (clr) begin
        m_digits.delete();
      end else if (ev) begin
        m_digits.push_front(d);
        if (m_digits.size() > 6) void'(m_digits.pop_back());
      end
    end else if (m_mode == 3) begin
      if (m_age == LOCKOUT_CYCLES - 1) begin
        m_mode = 0; m_fail = 0;
      end else begin
        m_age = m_age + 1;
      end
    end else if (clr) begin
      m_mode = 0;
    end
    exp_q.push_back(model_display());
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [41:0] exp_hex;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    exp_hex = exp_q.pop_front();
    check("hex", 64'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}), 64'(exp_hex));
    check("lockout", 64'(bus.lockout), 64'(m_mode == 3));
    check("state", 64'(bus.state_dbg), 64'(m_mode));
    if (m_mode != 3) check("fail_count", 64'(bus.fail_count), 64'(m_fail));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input int d, input bit ev, input bit dn, input bit op, input bit clr);
    bus.digit_in    = 4'(d);
    bus.entry_valid = ev;
    bus.done        = dn;
    bus.open        = op;
    bus.clear       = clr;
    @(posedge clk);
    model_step(d, ev, dn, op, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic mid_cycle_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.digit_in = 4'd0; bus.entry_valid = 1'b0; bus.done = 1'b0;
    bus.open = 1'b0; bus.clear = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // digit history, dash, and dropping of the oldest digit
    cycle(8, 1, 0, 0, 0);
    cycle(2, 1, 0, 0, 0);
    cycle(5, 1, 0, 0, 0);
    cycle(12, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(9, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    // open, then clear
    cycle(3, 0, 1, 1, 0);
    cycle(4, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    // three failures into lockout, with ignored strobes during lockout
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(6, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    idle(3);
    cycle(2, 1, 1, 1, 1);
    idle(4);
    // priority: done beats entry_valid; SHOW_CLOSED ignores digits
    cycle(7, 1, 1, 0, 0);
    cycle(7, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(3, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    // reach lockout again and reset at lock count 2
    cycle(0, 0, 1, 0, 0);
    idle(2);
    mid_cycle_reset();
    cycle(4, 1, 0, 0, 0);
    cycle(11, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
